// File: rtl/dadda_pkg.sv
// Shared definitions for the Dadda multiplier MAC datapath.
package dadda_pkg;

    // Width of an unsigned product coming out of the 8x8 Dadda multiplier.
    localparam int unsigned PROD_W = 16;

    // Frame FSM: ACC collects products, OUT presents the closed frame result.
    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_e;

endpackage

// File: rtl/dadda_mac_accumulator_if.sv
// Product-in / result-out handshake bundle for the MAC accumulator.
interface dadda_mac_accumulator_if #(
    parameter int unsigned PROD_W = dadda_pkg::PROD_W,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    // Producer of products and consumer of frame results.
    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_count, out_ovf
    );

    // The accumulator block itself.
    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_count, out_ovf
    );
endinterface

// File: rtl/dadda_mac_accumulator_fa_cell.sv
// Single-bit full adder cell used to build ripple-carry adders.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/dadda_mac_accumulator_rca_adder.sv
// W-bit ripple-carry adder built by chaining full-adder cells.
module rca_adder #(
    parameter int unsigned W = 24
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        fa_cell u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[W];
endmodule

// File: rtl/dadda_mac_accumulator.sv
// Multiply-accumulate back end: sums a frame of unsigned products into a wide
// accumulator and presents sum, product count and sticky overflow per frame.
// ACC_W must be at least PROD_W.
module dadda_mac_accumulator #(
    parameter int unsigned PROD_W = dadda_pkg::PROD_W,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    dadda_mac_accumulator_if.slave bus
);
    import dadda_pkg::*;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             rdy_q;
    logic             load_out;

    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] sum;
    logic             carry;
    logic [CNT_W-1:0] cnt_inc;
    logic             in_ready;
    logic             fire;

    logic [ACC_W-1:0] out_acc_q;
    logic [CNT_W-1:0] out_cnt_q;
    logic             out_ovf_q;

    assign addend  = ACC_W'(bus.in_prod);
    // Counter saturates at all-ones; acc and ovf keep updating regardless.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    // rdy_q holds in_ready low through reset and for the first edge after it.
    assign in_ready = rdy_q & (state_q == ACC);
    assign fire     = bus.in_valid & in_ready;

    rca_adder #(
        .W (ACC_W)
    ) u_rca_adder (
        .a    (acc_q),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (carry)
    );

    // Next-state and accumulator update for the frame FSM.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        load_out = 1'b0;
        case (state_q)
            ACC: begin
                if (fire) begin
                    acc_d = sum;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | carry;
                    if (bus.in_last) begin
                        load_out = 1'b1;
                        state_d  = OUT;
                    end
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    // FSM state and running frame registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Input-ready enable, set on the first edge out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    // Result registers, loaded only when the last product of a frame lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_acc_q <= '0;
            out_cnt_q <= '0;
            out_ovf_q <= 1'b0;
        end else if (load_out) begin
            out_acc_q <= acc_d;
            out_cnt_q <= cnt_d;
            out_ovf_q <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_acc   = out_acc_q;
    assign bus.out_count = out_cnt_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_dadda_mac_accumulator.sv
// Self-checking bench for dadda_mac_accumulator: directed frames plus
// randomized frames scored against a plain-arithmetic frame model.
module tb_dadda_mac_accumulator;
    localparam int unsigned PW  = 16;
    localparam int unsigned AW0 = 24;
    localparam int unsigned AW1 = 16;
    localparam int unsigned CW  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] stim[$];

    dadda_mac_accumulator_if #(.PROD_W(PW), .ACC_W(AW0), .CNT_W(CW)) if0 ();
    dadda_mac_accumulator_if #(.PROD_W(PW), .ACC_W(AW1), .CNT_W(CW)) if1 ();

    dadda_mac_accumulator #(.PROD_W(PW), .ACC_W(AW0), .CNT_W(CW)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    dadda_mac_accumulator #(.PROD_W(PW), .ACC_W(AW1), .CNT_W(CW)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: observed timeout, expected simulation end");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sends the products in stim as one frame on if0 and scores the result.
    task automatic frame0(input string tag, input int gap_max, input int bp_lo, input int bp_hi);
        longint unsigned tot = 0;
        int              n = stim.size();
        logic [23:0]     e_acc;
        logic [7:0]      e_cnt;
        logic            e_ovf;
        bit              rdy;
        int              guard;
        int              bp;
        foreach (stim[i]) tot += longint'(stim[i]);
        e_acc = tot[23:0];
        e_ovf = (tot >> 24) != 0;
        e_cnt = (n > 255) ? 8'd255 : 8'(n);
        for (int i = 0; i < n; i++) begin
            if (gap_max > 0) begin
                if0.in_valid = 1'b0;
                repeat ($urandom_range(gap_max, 0)) step();
            end
            if0.in_valid = 1'b1;
            if0.in_prod  = stim[i];
            if0.in_last  = (i == n - 1);
            guard = 0;
            do begin
                rdy = if0.in_ready;
                step();
                guard++;
            end while (!rdy && guard < 50);
            if (!rdy) chk({tag, " accept"}, 64'(rdy), 64'd1);
        end
        if0.in_valid = 1'b0;
        if0.in_last  = 1'b0;
        chk({tag, " out_valid"}, 64'(if0.out_valid), 64'd1);
        chk({tag, " in_ready_out"}, 64'(if0.in_ready), 64'd0);
        chk({tag, " out_acc"}, 64'(if0.out_acc), 64'(e_acc));
        chk({tag, " out_count"}, 64'(if0.out_count), 64'(e_cnt));
        chk({tag, " out_ovf"}, 64'(if0.out_ovf), 64'(e_ovf));
        bp = int'($urandom_range(bp_hi, bp_lo));
        for (int k = 0; k < bp; k++) begin
            if0.in_valid  = 1'($urandom_range(1, 0));
            if0.in_prod   = 16'($urandom);
            if0.in_last   = 1'($urandom_range(1, 0));
            if0.out_ready = 1'b0;
            step();
            chk({tag, " hold_valid"}, 64'(if0.out_valid), 64'd1);
            chk({tag, " hold_in_ready"}, 64'(if0.in_ready), 64'd0);
            chk({tag, " hold_acc"}, 64'(if0.out_acc), 64'(e_acc));
            chk({tag, " hold_count"}, 64'(if0.out_count), 64'(e_cnt));
            chk({tag, " hold_ovf"}, 64'(if0.out_ovf), 64'(e_ovf));
        end
        if0.in_valid  = 1'b0;
        if0.in_last   = 1'b0;
        if0.out_ready = 1'b1;
        step();
        chk({tag, " drained_valid"}, 64'(if0.out_valid), 64'd0);
        chk({tag, " drained_in_ready"}, 64'(if0.in_ready), 64'd1);
        if0.out_ready = 1'b0;
    endtask

    initial begin
        int n;
        bit big;
        if0.in_valid = 1'b0; if0.in_prod = '0; if0.in_last = 1'b0; if0.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.in_prod = '0; if1.in_last = 1'b0; if1.out_ready = 1'b0;

        // Reset state.
        step();
        step();
        chk("rst out_valid", 64'(if0.out_valid), 64'd0);
        chk("rst in_ready", 64'(if0.in_ready), 64'd0);
        chk("rst out_acc", 64'(if0.out_acc), 64'd0);
        chk("rst out_count", 64'(if0.out_count), 64'd0);
        chk("rst out_ovf", 64'(if0.out_ovf), 64'd0);
        rst = 1'b0;
        chk("post_rst in_ready_pre_edge", 64'(if0.in_ready), 64'd0);
        step();
        chk("post_rst in_ready", 64'(if0.in_ready), 64'd1);

        // Basic three-product frame, immediate drain.
        stim = '{16'h0003, 16'h0005, 16'h0007};
        frame0("basic", 0, 0, 0);

        // Single max product, held under backpressure for 5 cycles.
        stim = '{16'hFFFF};
        frame0("single_bp", 0, 5, 5);

        // ACC_W=16 instance: wrap and sticky overflow, then overflow clears.
        if1.in_valid = 1'b1; if1.in_prod = 16'hFFFF; if1.in_last = 1'b0;
        step();
        if1.in_prod = 16'h0002; if1.in_last = 1'b1;
        step();
        if1.in_valid = 1'b0; if1.in_last = 1'b0;
        chk("w16 out_valid", 64'(if1.out_valid), 64'd1);
        chk("w16 out_acc", 64'(if1.out_acc), 64'h0001);
        chk("w16 out_ovf", 64'(if1.out_ovf), 64'd1);
        chk("w16 out_count", 64'(if1.out_count), 64'd2);
        if1.out_ready = 1'b1;
        step();
        if1.out_ready = 1'b0;
        chk("w16 drained", 64'(if1.out_valid), 64'd0);
        if1.in_valid = 1'b1; if1.in_prod = 16'h0001; if1.in_last = 1'b1;
        step();
        if1.in_valid = 1'b0; if1.in_last = 1'b0;
        chk("w16b out_acc", 64'(if1.out_acc), 64'h0001);
        chk("w16b out_ovf", 64'(if1.out_ovf), 64'd0);
        chk("w16b out_count", 64'(if1.out_count), 64'd1);
        if1.out_ready = 1'b1;
        step();
        if1.out_ready = 1'b0;

        // 300 unit products: count saturates, sum does not.
        stim.delete();
        repeat (300) stim.push_back(16'h0001);
        frame0("sat300", 0, 0, 0);

        // Reset in the middle of a frame discards the partial sum.
        if0.in_valid = 1'b1; if0.in_prod = 16'h0100; if0.in_last = 1'b0;
        step();
        step();
        if0.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst out_valid", 64'(if0.out_valid), 64'd0);
        chk("midrst in_ready", 64'(if0.in_ready), 64'd0);
        step();
        chk("midrst in_ready_held", 64'(if0.in_ready), 64'd0);
        chk("midrst out_acc_clr", 64'(if0.out_acc), 64'd0);
        chk("midrst out_count_clr", 64'(if0.out_count), 64'd0);
        rst = 1'b0;
        step();
        chk("midrst in_ready_back", 64'(if0.in_ready), 64'd1);
        stim = '{16'h0010};
        frame0("after_rst", 0, 0, 0);

        // Randomized frames with input gaps and output backpressure.
        for (int f = 0; f < 1000; f++) begin
            big = ($urandom_range(49, 0) == 0);
            n   = big ? 300 : int'($urandom_range(8, 1));
            stim.delete();
            for (int i = 0; i < n; i++) begin
                if (big) stim.push_back(16'hFFFF - 16'($urandom_range(255, 0)));
                else     stim.push_back(16'($urandom));
            end
            frame0("rand", 3, 0, 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dadda_mac_accumulator.md
# dadda_mac_accumulator

- Downstream consumer of the 8-bit Dadda multiplier: accepts its 16-bit unsigned products over a valid/ready handshake and sums them into a wider accumulator.
- A product tagged last closes the frame; the block then presents the sum, product count and overflow flag until the consumer takes them.
- Turns the combinational multiplier array into a multiply-accumulate datapath for dot-product style workloads.

## Interface
- PROD_W, 16, product width (multiplier output width)
- ACC_W, 24, accumulator width; must be ≥ PROD_W
- CNT_W, 8, frame product-counter width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_prod/in_last valid
- in_ready  output  1  block can accept a product
- in_prod  input  PROD_W  unsigned product from multiplier
- in_last  input  1  product is final of frame
- out_valid  output  1  frame result valid
- out_ready  input  1  consumer takes result
- out_acc  output  ACC_W  frame sum (modulo 2^ACC_W)
- out_count  output  CNT_W  products accepted in frame (saturating)
- out_ovf  output  1  sticky: sum carried out of ACC_W during frame

## Operation
- States: ACC, OUT. Reset state ACC.
- Reset (async, any time, including mid-frame or in OUT) clears:
  - acc, count, ovf to 0
  - state to ACC
  - out_valid = 0
  - in_ready returns to 1 on the first clk edge after rst deasserts; it is 0 while rst is asserted
- ACC state:
  - in_ready = 1, out_valid = 0
  - Handshake fires when in_valid & in_ready at a rising edge.
  - On fire: acc ← acc + zero_extend(in_prod); ovf ← ovf | carry_out; count ← min(count+1, 2^CNT_W−1).
  - On fire with in_last = 1: the updated values are latched into the output registers and the state goes to OUT.
  - A product of 0 still counts.
- OUT state:
  - in_ready = 0, out_valid = 1
  - out_acc/out_count/out_ovf are held stable while out_valid & !out_ready.
  - in_valid is ignored.
  - On out_valid & out_ready: acc, count and ovf clear to 0; state goes to ACC.
- Arithmetic:
  - Unsigned only.
  - Wrap-around is modular; no saturation of acc.
  - Overflow is reported solely through sticky out_ovf.
- Count saturation does not affect acc or ovf.
- out_acc, out_count, out_ovf are registered and read 0 after reset until the first frame completes.

## Timing
- Accepted product to out_valid: 1 cycle. A product with in_last that fires at edge t gives out_valid high after edge t.
- out_ready sampled high at edge t+1 → out_valid low and in_ready high after edge t+1. This is a single mandatory bubble: back-to-back frames sustain at most one product per cycle within a frame plus one extra cycle per frame.
- in_ready has no combinational path from in_valid. out_valid has no combinational path from out_ready.
- Single-product frame (in_last on first beat) is legal: count = 1.

## Structure
- Shared package (dadda_pkg) holds:
  - PROD_W default 16
  - state enum {ACC, OUT}
- Natural sub-module: rca_adder, ACC_W-bit ripple-carry adder.
  - Built by generate-chaining the team's existing FA cell.
  - cin = 0; carry out drives the ovf update.
- Top module contains:
  - FSM
  - acc/count/ovf registers
  - output registers

## Test plan
- Reset then frame {0x0003, 0x0005, 0x0007 last}, out_ready high → out_valid one cycle after last beat; out_acc=15, out_count=3, out_ovf=0; in_ready high the cycle after.
- Single beat 0xFFFF last, out_ready held low 5 cycles → out_acc=0x00FFFF, count=1 stable for all 5 cycles; in_ready=0 throughout; in_valid pulses ignored.
- ACC_W=16, frame {0xFFFF, 0x0002 last} → out_acc=0x0001, out_ovf=1. The next frame {0x0001 last} gives out_ovf=0 (sticky cleared per frame).
- 300 beats of 0x0001 with CNT_W=8 → out_count=255, out_acc=300, out_ovf=0.
- rst asserted after two beats mid-frame, then frame {0x0010 last} → out_acc=0x10, count=1. During rst: out_valid=0, in_ready=0.
- Randomized in_valid/out_ready gaps over 1000 frames against a reference model → no lost or duplicated products; outputs stable under backpressure.
